// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run/stop and reconfiguration controller for the fabric clock
// divider. Produces a 50%-duty divided clock (div_out) plus a toggle strobe
// (tick). New half-period values arrive over a valid/ready handshake and are
// only applied on a period boundary (falling edge of div_out) or while idle,
// so downstream logic never sees a runt or stretched phase. Stopping also
// waits for a completed period, so div_out always parks low.
module clk_div_ctrl #(
    parameter int CNT_W    = 16,
    parameter int DEF_HALF = 4999,
    parameter int MIN_HALF = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             busy,
    output logic             div_out,
    output logic             tick,
    output logic             err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [CNT_W-1:0] DEF_HALF_V = CNT_W'(DEF_HALF);
    localparam logic [CNT_W-1:0] MIN_HALF_V = CNT_W'(MIN_HALF);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] active_half_reg, active_half_next;
    logic [CNT_W-1:0] pend_half_reg, pend_half_next;
    logic             pend_vld_reg, pend_vld_next;
    logic             div_out_reg, div_out_next;
    logic             tick_reg, tick_next;
    logic             err_reg, err_next;

    logic counting;
    logic term;
    logic xfer;
    logic apply;

    // Event decode: phase terminal count, handshake transfer and config apply.
    always_comb begin
        counting = (state_reg == S_RUN) || (state_reg == S_DRAIN);
        term     = counting && (count_reg == active_half_reg);
        xfer     = cfg_valid && !pend_vld_reg;
        // Apply only while idle or on a falling edge (period boundary); the
        // terminal cycle itself still compares against the old value.
        apply    = pend_vld_reg && ((state_reg == S_IDLE) || (term && div_out_reg));
    end

    // Next-state logic for the FSM, phase counter, divided clock and config slot.
    always_comb begin
        state_next       = state_reg;
        count_next       = '0;
        div_out_next     = div_out_reg;
        tick_next        = 1'b0;
        err_next         = 1'b0;
        active_half_next = active_half_reg;
        pend_half_next   = pend_half_reg;
        pend_vld_next    = pend_vld_reg;

        case (state_reg)
            S_IDLE: begin
                div_out_next = 1'b0;
                if (run) begin
                    state_next = S_RUN;
                end
            end
            S_RUN, S_DRAIN: begin
                // Leaving RUN for DRAIN does not disturb the counter; a
                // falling edge with run low is a completed period, so stop.
                if (term && div_out_reg && !run) begin
                    state_next = S_IDLE;
                end else if (!run) begin
                    state_next = S_DRAIN;
                end else begin
                    state_next = S_RUN;
                end
                if (term) begin
                    div_out_next = ~div_out_reg;
                    tick_next    = 1'b1;
                end else begin
                    count_next   = count_reg + 1'b1;
                end
            end
            default: begin
                state_next   = S_IDLE;
                div_out_next = 1'b0;
            end
        endcase

        // A transfer needs an empty slot and an apply needs a full one, so
        // the two never collide in the same cycle.
        if (xfer) begin
            if (cfg_half < MIN_HALF_V) begin
                err_next = 1'b1;
            end else begin
                pend_half_next = cfg_half;
                pend_vld_next  = 1'b1;
            end
        end
        if (apply) begin
            active_half_next = pend_half_reg;
            pend_vld_next    = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset; pending config is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            count_reg       <= '0;
            active_half_reg <= DEF_HALF_V;
            pend_half_reg   <= '0;
            pend_vld_reg    <= 1'b0;
            div_out_reg     <= 1'b0;
            tick_reg        <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            active_half_reg <= active_half_next;
            pend_half_reg   <= pend_half_next;
            pend_vld_reg    <= pend_vld_next;
            div_out_reg     <= div_out_next;
            tick_reg        <= tick_next;
            err_reg         <= err_next;
        end
    end

    assign cfg_ready = ~pend_vld_reg;
    assign busy      = (state_reg != S_IDLE);
    assign div_out   = div_out_reg;
    assign tick      = tick_reg;
    assign err       = err_reg;

endmodule
